csa_err_recovery: RTL and testbench
===================================

Name: csa_err_recovery

Overview:
- Stage directly downstream of the carry-speculative adder's error-detect block.
- Latches the speculative sum together with the error flag produced by the detector.
- When the flag is clear, forwards the speculative result after one cycle.
- When the flag is set, discards the speculative sum and recomputes the exact sum block-by-block, one BLK-bit block per cycle, before presenting it downstream under a valid/ready handshake.

Parameters:
- WIDTH, 16, operand and sum width in bits.
- BLK, 4, speculative block size in bits, which is also the correction slice per cycle. WIDTH must be a multiple of BLK, giving NBLK = WIDTH/BLK.
- CNT_W, 16, width of the saturating correction counter.

Ports:
- clk  input  1  Rising-edge clock.
- rst_n  input  1  Asynchronous, active-low reset.
- in_valid  input  1  Upstream operand, speculative sum and error flag are valid.
- in_ready  output  1  Block accepts the upstream transfer this cycle.
- a  input  WIDTH  Operand A.
- b  input  WIDTH  Operand B.
- cin  input  1  Carry-in.
- spec_sum  input  WIDTH  Speculative sum from the adder.
- spec_cout  input  1  Speculative carry-out.
- err  input  1  Error-detect flag; 1 means the speculative result is wrong.
- out_valid  output  1  sum/cout/corrected are valid.
- out_ready  input  1  Downstream accepts the result.
- sum  output  WIDTH  Final (exact) sum.
- cout  output  1  Final carry-out.
- corrected  output  1  Result came from the recovery path.
- busy  output  1  High while in RECOVER.
- corr_count  output  CNT_W  Number of corrections performed; saturates at all-ones.

Behaviour:
- Reset (async assert, sync deassert on clk): state=IDLE. sum=0, cout=0, corrected=0, out_valid=0, busy=0, corr_count=0, internal carry and block index 0. Outputs zero immediately on rst_n low, including during RECOVER; any in-flight operation is dropped.
- States: IDLE, RECOVER, HOLD.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). Transfer occurs when in_valid & in_ready.
- Accept with err=0:
  - Next cycle: sum<=spec_sum, cout<=spec_cout, corrected<=0, out_valid<=1, state->HOLD.
  - Latency 1 cycle.
- Accept with err=1:
  - Capture a, b, cin into internal registers; carry<=cin, idx<=0, state->RECOVER, busy=1, out_valid=0.
  - spec_sum and spec_cout are ignored.
- RECOVER, each cycle:
  - sum[idx*BLK +: BLK] <= a_blk + b_blk + carry (BLK+1-bit add); carry <= its MSB; idx++.
  - On idx==NBLK-1: cout<=final carry, corrected<=1, out_valid<=1, corr_count++ (held at 2^CNT_W-1 once reached), state->HOLD, busy=0.
  - Error-path latency = NBLK cycles after acceptance (4 for defaults).
  - in_ready=0 throughout.
- HOLD:
  - Outputs stable while out_valid & !out_ready.
  - On out_ready: if a new transfer is accepted the same cycle, process it as from IDLE (back-to-back, no bubble on the clean path). Otherwise out_valid<=0 and state->IDLE.
- Exactness: on corrected=1, {cout,sum} == a+b+cin exactly (WIDTH+1 bits). On corrected=0, the block passes speculative data unmodified.
- in_valid while in_ready=0: ignored. Upstream holds its data.
- err is sampled only on a transfer cycle.

Test Plan:
- Clean path: a=0x1234, b=0x0101, cin=0, spec_sum=0x1335, err=0 -> out_valid 1 cycle later, sum=0x1335, cout=0, corrected=0, corr_count=0.
- Correction: a=0x00FF, b=0x0001, cin=0, spec_sum=0x00F0 (wrong), err=1 -> busy for 4 cycles, then sum=0x0100, cout=0, corrected=1, corr_count=1.
- Full-width carry: a=0xFFFF, b=0x0001, cin=0, err=1 -> sum=0x0000, cout=1 after 4 cycles. Also a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
- Backpressure/back-to-back: hold out_ready=0 for 3 cycles after a result -> sum stable, in_ready=0. Then out_ready=1 with a new clean input in the same cycle -> new result valid the next cycle with no idle gap.
- Reset mid-recovery: assert rst_n=0 at recovery cycle 2 -> all outputs 0 immediately. After release, a clean transfer completes normally and corr_count=0.
- Counter saturation (CNT_W=2): 5 consecutive err=1 transfers -> corr_count reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/csa_err_recovery.sv
// csa_err_recovery
// Stage behind the carry-speculative adder's error detector. A clean
// speculative result is forwarded after one cycle. A flagged result is
// dropped. The exact sum is then rebuilt one BLK-bit block per cycle,
// starting from the LSB block, using the captured operands.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake (a, b, cin, spec_sum, spec_cout, err)
//   out_valid/out_ready downstream handshake (sum, cout, corrected)
//   busy                high while the exact sum is being rebuilt
//   corr_count          saturating count of completed corrections
module csa_err_recovery #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [WIDTH-1:0] spec_sum,
    input  logic             spec_cout,
    input  logic             err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             corrected,
    output logic             busy,
    output logic [CNT_W-1:0] corr_count
);

    localparam int NBLK  = WIDTH / BLK;
    localparam int IDX_W = (NBLK > 1) ? $clog2(NBLK) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECOVER = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic              in_ready_s;
    logic              xfer_s;
    logic              last_s;
    logic [BLK:0]      blk_sum_s;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic              carry_r;
    logic [IDX_W-1:0]  idx_r;
    logic [WIDTH-1:0]  sum_r;
    logic              cout_r;
    logic              corrected_r;
    logic              out_valid_r;
    logic              busy_r;
    logic [CNT_W-1:0]  corr_count_r;

    // Exact (BLK+1)-bit add of one operand slice plus incoming carry.
    function automatic logic [BLK:0] blk_add(input logic [BLK-1:0] x,
                                             input logic [BLK-1:0] y,
                                             input logic           c);
        return {1'b0, x} + {1'b0, y} + {{BLK{1'b0}}, c};
    endfunction

    // Handshake, current correction slice and next-state decode.
    always_comb begin
        in_ready_s  = (state_r == IDLE) | ((state_r == HOLD) & out_ready);
        xfer_s      = in_valid & in_ready_s;
        last_s      = (idx_r == IDX_W'(NBLK - 1));
        blk_sum_s   = blk_add(a_r[idx_r*BLK +: BLK], b_r[idx_r*BLK +: BLK], carry_r);
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (xfer_s) begin
                    state_nxt_s = err ? RECOVER : HOLD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RECOVER: begin
                if (last_s) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = RECOVER;
                end
            end
            HOLD: begin
                if (xfer_s) begin
                    state_nxt_s = err ? RECOVER : HOLD;
                end else if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture, block-serial correction and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r          <= {WIDTH{1'b0}};
            b_r          <= {WIDTH{1'b0}};
            carry_r      <= 1'b0;
            idx_r        <= {IDX_W{1'b0}};
            sum_r        <= {WIDTH{1'b0}};
            cout_r       <= 1'b0;
            corrected_r  <= 1'b0;
            out_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            corr_count_r <= {CNT_W{1'b0}};
        end else if (state_r == RECOVER) begin
            sum_r[idx_r*BLK +: BLK] <= blk_sum_s[BLK-1:0];
            carry_r                 <= blk_sum_s[BLK];
            idx_r                   <= idx_r + IDX_W'(1);
            if (last_s) begin
                cout_r      <= blk_sum_s[BLK];
                corrected_r <= 1'b1;
                out_valid_r <= 1'b1;
                busy_r      <= 1'b0;
                if (corr_count_r != {CNT_W{1'b1}}) begin
                    corr_count_r <= corr_count_r + CNT_W'(1);
                end else begin
                    corr_count_r <= corr_count_r;
                end
            end else begin
                busy_r <= 1'b1;
            end
        end else if (xfer_s) begin
            if (!err) begin
                sum_r       <= spec_sum;
                cout_r      <= spec_cout;
                corrected_r <= 1'b0;
                out_valid_r <= 1'b1;
            end else begin
                // Speculative data is discarded; only operands matter now.
                a_r         <= a;
                b_r         <= b;
                carry_r     <= cin;
                idx_r       <= {IDX_W{1'b0}};
                corrected_r <= 1'b0;
                out_valid_r <= 1'b0;
                busy_r      <= 1'b1;
            end
        end else if ((state_r == HOLD) && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign sum        = sum_r;
    assign cout       = cout_r;
    assign corrected  = corrected_r;
    assign busy       = busy_r;
    assign corr_count = corr_count_r;

endmodule

// File: tb/tb_csa_err_recovery.sv
// Self-checking bench for csa_err_recovery: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// transaction-level model. A second instance with a 2-bit counter checks
// saturation.
module tb_csa_err_recovery;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready, in_ready2;
    logic [15:0] a = 16'h0, b = 16'h0, spec_sum = 16'h0;
    logic        cin = 1'b0, spec_cout = 1'b0, err = 1'b0;
    logic        out_valid, out_valid2;
    logic        out_ready = 1'b1;
    logic [15:0] sum, sum2;
    logic        cout, cout2, corrected, corrected2, busy, busy2;
    logic [15:0] corr_count;
    logic [1:0]  corr_count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    csa_err_recovery #(.WIDTH(16), .BLK(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .spec_sum(spec_sum), .spec_cout(spec_cout),
        .err(err), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .corrected(corrected), .busy(busy), .corr_count(corr_count)
    );

    csa_err_recovery #(.WIDTH(16), .BLK(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .cin(cin), .spec_sum(spec_sum), .spec_cout(spec_cout),
        .err(err), .out_valid(out_valid2), .out_ready(out_ready), .sum(sum2),
        .cout(cout2), .corrected(corrected2), .busy(busy2), .corr_count(corr_count2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Transaction view: a held result, or a countdown of correction cycles
    // after which the exact result a+b+cin appears.
    logic        m_valid;
    logic [15:0] m_sum;
    logic        m_cout, m_corr;
    int          m_left;
    logic [16:0] m_res;
    int          m_cnt, m_cnt2;
    logic        m_in_ready, m_xfer;

    assign m_in_ready = (m_left == 0 && !m_valid) || (m_valid && out_ready);
    assign m_xfer     = in_valid && m_in_ready;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0; m_sum <= 16'h0; m_cout <= 1'b0; m_corr <= 1'b0;
            m_left <= 0; m_res <= 17'h0; m_cnt <= 0; m_cnt2 <= 0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_valid <= 1'b1;
                m_sum   <= m_res[15:0];
                m_cout  <= m_res[16];
                m_corr  <= 1'b1;
                m_cnt   <= (m_cnt == 65535) ? m_cnt : m_cnt + 1;
                m_cnt2  <= (m_cnt2 == 3) ? m_cnt2 : m_cnt2 + 1;
            end
        end else if (m_xfer) begin
            if (!err) begin
                m_valid <= 1'b1; m_sum <= spec_sum; m_cout <= spec_cout; m_corr <= 1'b0;
            end else begin
                m_valid <= 1'b0;
                m_left  <= 4;
                m_res   <= {1'b0, a} + {1'b0, b} + {16'h0, cin};
            end
        end else if (m_valid && out_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        chk("busy", {31'b0, busy}, {31'b0, m_left != 0});
        chk("in_ready", {31'b0, in_ready}, {31'b0, m_in_ready});
        chk("corr_count", {16'b0, corr_count}, m_cnt);
        chk("out_valid2", {31'b0, out_valid2}, {31'b0, m_valid});
        chk("corr_count2", {30'b0, corr_count2}, m_cnt2);
        if (m_valid) begin
            chk("sum", {16'b0, sum}, {16'b0, m_sum});
            chk("cout", {31'b0, cout}, {31'b0, m_cout});
            chk("corrected", {31'b0, corrected}, {31'b0, m_corr});
        end
    end

    // ---------------- directed helpers ----------------
    task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                        input logic [15:0] ts, input logic tsc, input logic te);
        logic ok;
        ok = 1'b0;
        a = ta; b = tb; cin = tc; spec_sum = ts; spec_cout = tsc; err = te;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
        chk("send_accepted", {31'b0, ok}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string nm, input logic [15:0] es, input logic ec,
                            input logic ecor, input logic [15:0] ecnt);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk({nm, "_valid"}, {31'b0, ok}, 32'd1);
        chk({nm, "_sum"}, {16'b0, sum}, {16'b0, es});
        chk({nm, "_cout"}, {31'b0, cout}, {31'b0, ec});
        chk({nm, "_corrected"}, {31'b0, corrected}, {31'b0, ecor});
        chk({nm, "_count"}, {16'b0, corr_count}, {16'b0, ecnt});
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) n++;
            if (out_valid) break;
        end
    endtask

    initial begin
        int nb;
        logic [1:0] sat_exp [5];
        sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
        sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

        // Reset state.
        #2;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_sum", {16'b0, sum}, 32'd0);
        chk("rst_cout", {31'b0, cout}, 32'd0);
        chk("rst_corrected", {31'b0, corrected}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_count", {16'b0, corr_count}, 32'd0);
        #20;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Clean path: one cycle latency.
        send(16'h1234, 16'h0101, 1'b0, 16'h1335, 1'b0, 1'b0);
        @(negedge clk);
        chk("clean_latency", {31'b0, out_valid}, 32'd1);
        chk("clean_sum", {16'b0, sum}, 32'h1335);
        chk("clean_count", {16'b0, corr_count}, 32'd0);
        @(posedge clk); #1;

        // Correction path: busy for 4 cycles.
        send(16'h00FF, 16'h0001, 1'b0, 16'h00F0, 1'b0, 1'b1);
        count_busy(nb);
        chk("corr_busy_cycles", nb, 32'd4);
        chk("corr_sum", {16'b0, sum}, 32'h0100);
        chk("corr_cout", {31'b0, cout}, 32'd0);
        chk("corr_corrected", {31'b0, corrected}, 32'd1);
        chk("corr_count", {16'b0, corr_count}, 32'd1);
        @(posedge clk); #1;

        // Full-width carry propagation.
        send(16'hFFFF, 16'h0001, 1'b0, 16'h1111, 1'b0, 1'b1);
        wait_out("carry1", 16'h0000, 1'b1, 1'b1, 16'd2);
        @(posedge clk); #1;
        send(16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 1'b1);
        wait_out("carry2", 16'hFFFF, 1'b1, 1'b1, 16'd3);
        @(posedge clk); #1;

        // Backpressure then back-to-back clean transfer.
        out_ready = 1'b0;
        send(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);
        a = 16'h0010; b = 16'h0020; cin = 1'b0; spec_sum = 16'h0030; spec_cout = 1'b1; err = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_sum_stable", {16'b0, sum}, 32'h0003);
            chk("bp_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("b2b_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_valid", {31'b0, out_valid}, 32'd1);
        chk("b2b_sum", {16'b0, sum}, 32'h0030);
        chk("b2b_cout", {31'b0, cout}, 32'd1);
        @(posedge clk); #1;

        // Reset in the middle of a correction.
        send(16'h0F0F, 16'h0101, 1'b1, 16'h0000, 1'b0, 1'b1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_sum", {16'b0, sum}, 32'd0);
        chk("mid_rst_cout", {31'b0, cout}, 32'd0);
        chk("mid_rst_corrected", {31'b0, corrected}, 32'd0);
        chk("mid_rst_count", {16'b0, corr_count}, 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b0);
        wait_out("post_rst", 16'h8000, 1'b0, 1'b0, 16'd0);
        @(posedge clk); #1;

        // Counter saturation on the 2-bit instance.
        for (int k = 0; k < 5; k++) begin
            send(16'h1000 + 16'(k), 16'h0F00, 1'b0, 16'h0000, 1'b0, 1'b1);
            wait_out("sat", 16'h1F00 + 16'(k), 1'b0, 1'b1, 16'(k + 1));
            chk("sat_count2", {30'b0, corr_count2}, {30'b0, sat_exp[k]});
            @(posedge clk); #1;
        end

        // Randomized traffic checked by the model every cycle.
        for (int i = 0; i < 800; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            err       = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: a = 16'hFFFF;
                1: a = 16'h0000;
                default: a = 16'($urandom);
            endcase
            b         = ($urandom_range(0, 3) == 0) ? 16'h0001 : 16'($urandom);
            cin       = $urandom_range(0, 1);
            spec_sum  = 16'($urandom);
            spec_cout = $urandom_range(0, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
